// File: rtl/mtm_pkg.sv
// mtm_pkg: constants and helpers shared by the matrix-transpose path.
package mtm_pkg;

    localparam int MTM_DATA_WIDTH = 8;
    localparam int MTM_NUM_PE     = 4;

    // Index width that stays at least one bit, so a 1-PE build still elaborates.
    function automatic int idx_w(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/mtm_tile_bank.sv
// mtm_tile_bank: NUM_PE x NUM_PE register tile with indexed row write and combinational row read.
module mtm_tile_bank
    import mtm_pkg::*;
#(
    parameter int DATA_WIDTH = MTM_DATA_WIDTH,
    parameter int NUM_PE     = MTM_NUM_PE,
    localparam int IW        = idx_w(NUM_PE)
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 wr_en,
    input  logic [IW-1:0]                        wr_idx,
    input  logic [0:NUM_PE-1][DATA_WIDTH-1:0]    wr_row,
    input  logic [IW-1:0]                        rd_idx,
    output logic [0:NUM_PE-1][DATA_WIDTH-1:0]    rd_row
);

    typedef logic [0:NUM_PE-1][DATA_WIDTH-1:0] row_t;

    row_t mem_q [NUM_PE];
    row_t mem_d [NUM_PE];

    always_comb begin
        mem_d = mem_q;
        if (wr_en)
            mem_d[wr_idx] = wr_row;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst)
            mem_q <= '{default: '0};
        else
            mem_q <= mem_d;
    end

    assign rd_row = mem_q[rd_idx];

endmodule

// File: rtl/mtm_row_buffer.sv
// mtm_row_buffer: ping-pong tile buffer turning free-running transposed rows into
// whole tiles re-issued row by row over a valid/ready handshake.
module mtm_row_buffer
    import mtm_pkg::*;
#(
    parameter int DATA_WIDTH = MTM_DATA_WIDTH,
    parameter int NUM_PE     = MTM_NUM_PE
) (
    input  logic                                 clk,
    input  logic                                 rst,
    input  logic                                 in_val,
    input  logic [0:NUM_PE-1][DATA_WIDTH-1:0]    in_row,
    output logic                                 out_val,
    input  logic                                 out_ready,
    output logic [0:NUM_PE-1][DATA_WIDTH-1:0]    out_row,
    output logic                                 out_last,
    output logic [1:0]                           tiles_full,
    output logic                                 overflow
);

    localparam int IW = idx_w(NUM_PE);
    localparam logic [IW-1:0] LAST = IW'(NUM_PE - 1);

    typedef logic [0:NUM_PE-1][DATA_WIDTH-1:0] row_t;

    logic          wb_q, wb_d, rb_q, rb_d, ovf_q, ovf_d;
    logic [IW-1:0] wr_idx_q, wr_idx_d, rd_idx_q, rd_idx_d;
    logic [1:0]    full_q, full_d, full_set, full_clr, wr_en;
    row_t          rd_row [2];

    for (genvar b = 0; b < 2; b++) begin : g_bank
        mtm_tile_bank #(
            .DATA_WIDTH (DATA_WIDTH),
            .NUM_PE     (NUM_PE)
        ) u_bank (
            .clk    (clk),
            .rst    (rst),
            .wr_en  (wr_en[b]),
            .wr_idx (wr_idx_q),
            .wr_row (in_row),
            .rd_idx (rd_idx_q),
            .rd_row (rd_row[b])
        );
    end

    assign out_val    = full_q[rb_q];
    assign out_row    = rd_row[rb_q];
    assign out_last   = out_val && (rd_idx_q == LAST);
    assign tiles_full = {1'b0, full_q[0]} + {1'b0, full_q[1]};
    assign overflow   = ovf_q;

    // Set and clear never target the same bank: a bank is only written while
    // not full and only drained while full.
    always_comb begin
        wb_d     = wb_q;
        wr_idx_d = wr_idx_q;
        rb_d     = rb_q;
        rd_idx_d = rd_idx_q;
        ovf_d    = ovf_q;
        wr_en    = '0;
        full_set = '0;
        full_clr = '0;
        if (in_val && full_q[wb_q]) begin
            ovf_d = 1'b1;
        end else if (in_val) begin
            wr_en[wb_q] = 1'b1;
            if (wr_idx_q == LAST) begin
                full_set[wb_q] = 1'b1;
                wb_d           = ~wb_q;
                wr_idx_d       = '0;
            end else begin
                wr_idx_d = wr_idx_q + IW'(1);
            end
        end
        if (out_val && out_ready) begin
            if (rd_idx_q == LAST) begin
                full_clr[rb_q] = 1'b1;
                rb_d           = ~rb_q;
                rd_idx_d       = '0;
            end else begin
                rd_idx_d = rd_idx_q + IW'(1);
            end
        end
        full_d = (full_q & ~full_clr) | full_set;
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_q     <= 1'b0;
            wr_idx_q <= '0;
            rb_q     <= 1'b0;
            rd_idx_q <= '0;
            full_q   <= '0;
            ovf_q    <= 1'b0;
        end else begin
            wb_q     <= wb_d;
            wr_idx_q <= wr_idx_d;
            rb_q     <= rb_d;
            rd_idx_q <= rd_idx_d;
            full_q   <= full_d;
            ovf_q    <= ovf_d;
        end
    end

endmodule
